// File: rtl/serial_digit_adder_pkg.sv
// serial_digit_adder_pkg: shared FSM state type and counter sizing helper
package serial_digit_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_width(input int width, input int digit);
        return (width / digit) > 1 ? $clog2(width / digit) : 1;
    endfunction

endpackage

// File: rtl/serial_digit_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple of full-adder cells
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] c;

    assign c[0] = ci;
    assign co   = c[DIGIT];

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

endmodule

// File: rtl/serial_digit_adder.sv
// serial_digit_adder: WIDTH-bit adder working DIGIT bits per cycle with valid/ready handshakes; SERIAL_DIGIT_ADDER_SUB_EN adds sub/ovf
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_digit_adder: WIDTH must be a multiple of DIGIT");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [DIGIT-1:0] ds;
    logic             dco;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x  (a_sh[DIGIT-1:0]),
        .y  (b_sh[DIGIT-1:0]),
        .ci (carry),
        .s  (ds),
        .co (dco)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign sum       = sum_sh;
    assign cout      = carry;

    // handshake FSM and digit-serial datapath: one digit per RUN cycle, LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
                    b_sh  <= sub ? ~b : b;
                    carry <= sub | cin;
`else
                    b_sh  <= b;
                    carry <= cin;
`endif
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum_sh <= WIDTH'({ds, sum_sh} >> DIGIT);
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    carry  <= dco;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
                        ovf   <= (a_sh[DIGIT-1] == b_sh[DIGIT-1]) && (ds[DIGIT-1] != a_sh[DIGIT-1]);
`endif
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_digit_adder.sv
// tb_serial_digit_adder: randomized scoreboard bench for serial_digit_adder against an arithmetic reference model
module tb_serial_digit_adder;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        int               e0;
    } exp_t;

    logic             clk = 0, rst_n = 1, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
    logic             in_ready, out_valid, cout, busy;
    logic [WIDTH-1:0] a = '0, b = '0, sum;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    logic             ovf;
`endif

    exp_t             exp_q[$];
    int               checks = 0, errors = 0, cyc = 0;
    bit               seen = 0, rnd = 0, rdy_force = 1;
    logic [WIDTH-1:0] hs;
    logic             hc;

    serial_digit_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rnd ? ($urandom_range(0, 2) != 0) : rdy_force;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", n, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c, input logic sb);
        exp_t   e;
        longint r, sx, sy, sr;
        sx = x[WIDTH-1] ? longint'(x) - (longint'(1) << WIDTH) : longint'(x);
        sy = y[WIDTH-1] ? longint'(y) - (longint'(1) << WIDTH) : longint'(y);
        r  = sb ? longint'(x) + longint'(~y) + 1 : longint'(x) + longint'(y) + longint'(c);
        sr = sb ? sx - sy : sx + sy + longint'(c);
        e.s  = r[WIDTH-1:0];
        e.c  = r[WIDTH];
        e.v  = (sr > (longint'(1) << (WIDTH - 1)) - 1) || (sr < -(longint'(1) << (WIDTH - 1)));
        e.e0 = 0;
        return e;
    endfunction

    // monitor: push expectations on input handshakes, check latency, hold and results on output handshakes
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            seen = 0;
        end else begin
            if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
                    else chk("latency", cyc - exp_q[0].e0, N);
                    seen = 1;
                end else begin
                    chk("hold_sum", sum, hs);
                    chk("hold_cout", cout, hc);
                end
                hs = sum;
                hc = cout;
                if (out_ready) begin
                    seen = 0;
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("sum", sum, e.s);
                        chk("cout", cout, e.c);
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
                        chk("ovf", ovf, e.v);
`endif
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e    = model(a, b, cin, sub);
                e.e0 = cyc + 1;
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c, input logic sb);
        @(posedge clk);
        #1;
        a = x; b = y; cin = c; sub = sb; in_valid = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        send(16'h1234, 16'h4321, 0, 0);
        chk("busy_after_accept", busy, 1);
        chk("in_ready_after_accept", in_ready, 0);
        wait_done();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        send(16'hFFFF, 16'h0001, 0, 0);
        send(16'hFFFF, 16'hFFFF, 1, 0);
        wait_done();

        rdy_force = 0;
        send(16'h1234, 16'h4321, 0, 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("pend_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        a = 16'hAAAA; b = 16'h5555; cin = 1; sub = 0; in_valid = 1;
        repeat (10) begin
            @(negedge clk);
            chk("pend_in_ready", in_ready, 0);
            chk("pend_busy", busy, 1);
        end
        rdy_force = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_out_valid", out_valid, 0);
        @(posedge clk);
        #1 in_valid = 0;
        wait_done();

        send(16'h1111, 16'h2222, 0, 0);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_cout", cout, 0);
        @(posedge clk);
        #1 rst_n = 1;
        repeat (8) @(posedge clk);
        send(16'h0F0F, 16'h00F1, 0, 0);
        wait_done();

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        send(16'h0005, 16'h0007, 1, 1);
        send(16'h8000, 16'h0001, 0, 1);
        wait_done();
`endif

        rnd = 1;
        for (int k = 0; k < 200; k++) begin
            logic sb;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
            sb = 1'($urandom_range(0, 1));
`else
            sb = 0;
`endif
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), sb);
        end
        rnd = 0;
        wait_done();
        repeat (10) @(posedge clk);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
